// File: rtl/key_event_capture_if.sv
// CPU-side read bus of key_event_capture: read strobe, read data/valid and interrupt.
// KEY_RELEASE_EVT_EN widens rd_data to 24 bits so it can carry release events.
interface key_event_capture_if;
`ifdef KEY_RELEASE_EVT_EN
  localparam int RD_W = 24;
`else
  localparam int RD_W = 16;
`endif

  logic            rd_en;
  logic [RD_W-1:0] rd_data;
  logic            rd_valid;
  logic            irq;

  modport master (output rd_en, input rd_data, input rd_valid, input irq);
  modport slave  (input rd_en, output rd_data, output rd_valid, output irq);
endinterface

// File: rtl/key_event_capture.sv
// Push-button conditioner: 2-flop sync, counter debounce, sticky press events, clear-on-read.
// Optional macro KEY_RELEASE_EVT_EN adds sticky release events in rd_data[23:16].
module key_event_capture #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] key_level,
  key_event_capture_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef KEY_RELEASE_EVT_EN
  localparam int EW   = 2 * NKEYS;
  localparam int RD_W = 24;
`else
  localparam int EW   = NKEYS;
  localparam int RD_W = 16;
`endif

  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [NKEYS-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [NKEYS];
  logic [CW-1:0]    cnt_d [NKEYS];
  logic [EW-1:0]    evt_q, evt_d, evt_set;
  logic [RD_W-1:0]  rd_data_q, rd_data_d;
  logic             rd_valid_q;
  logic             irq_q;

  // Synchronizer flops reset to all ones so a released key looks released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // The stable state flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  always_comb begin
    for (int k = 0; k < NKEYS; k++) begin
      stable_d[k] = stable_q[k];
      cnt_d[k]    = '0;
      if (~sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[k] = ~stable_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

`ifdef KEY_RELEASE_EVT_EN
  assign evt_set = {~stable_d & stable_q, stable_d & ~stable_q};
`else
  assign evt_set = stable_d & ~stable_q;
`endif

  // New events are OR-ed in after the read clear, so an event never gets lost.
  always_comb begin
    evt_d     = (bus.rd_en ? '0 : evt_q) | evt_set;
    rd_data_d = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d                 = '0;
      rd_data_d[NKEYS-1:0]      = evt_q[NKEYS-1:0];
      rd_data_d[8 +: NKEYS]     = stable_q;
`ifdef KEY_RELEASE_EVT_EN
      rd_data_d[16 +: NKEYS]    = evt_q[NKEYS +: NKEYS];
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_q   <= '0;
      evt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
      for (int k = 0; k < NKEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      stable_q   <= stable_d;
      evt_q      <= evt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= bus.rd_en;
      irq_q      <= |evt_q;
      for (int k = 0; k < NKEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign key_level    = stable_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_key_event_capture.sv
// Self-checking bench for key_event_capture (NKEYS=4, DEBOUNCE_CYCLES=8) against a run-length key model.
// Honours KEY_RELEASE_EVT_EN the same way as the design.
module tb_key_event_capture;

  localparam int N = 4;
  localparam int D = 8;
`ifdef KEY_RELEASE_EVT_EN
  localparam int RD_W = 24;
`else
  localparam int RD_W = 16;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_level;
  int           compared = 0;
  int           mismatched = 0;

  key_event_capture_if bus ();

  key_event_capture #(.NKEYS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_n     (key_n),
    .key_level (key_level),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pin seen two edges late, level flips after D consecutive differing edges.
  logic [N-1:0]    mD1, mD2, mLvl;
  int              mRun [N];
  logic [7:0]      mPress, mRel;
  logic [RD_W-1:0] mRdData;
  logic            mValid, mIrq;

  task automatic modelReset();
    mD1 = '1; mD2 = '1; mLvl = '0;
    for (int k = 0; k < N; k++) mRun[k] = 0;
    mPress = '0; mRel = '0; mRdData = '0; mValid = 1'b0; mIrq = 1'b0;
  endtask

  task automatic modelStep();
    logic [N-1:0]    seen, nl;
    logic [7:0]      newP, newR;
    logic [RD_W-1:0] snap;
    seen = ~mD2; mD2 = mD1; mD1 = key_n;
    nl = mLvl; newP = '0; newR = '0;
    for (int k = 0; k < N; k++) begin
      if (seen[k] != mLvl[k]) begin
        mRun[k]++;
        if (mRun[k] == D) begin
          nl[k] = ~mLvl[k];
          mRun[k] = 0;
          if (nl[k]) newP[k] = 1'b1; else newR[k] = 1'b1;
        end
      end else begin
        mRun[k] = 0;
      end
    end
`ifdef KEY_RELEASE_EVT_EN
    mIrq = (mPress != 0) || (mRel != 0);
`else
    newR = '0;
    mIrq = (mPress != 0);
`endif
    mValid = bus.rd_en;
    if (bus.rd_en) begin
      snap = '0;
      snap[7:0]  = mPress;
      snap[15:8] = {4'b0, mLvl};
`ifdef KEY_RELEASE_EVT_EN
      snap[23:16] = mRel;
`endif
      mRdData = snap;
      mPress = newP; mRel = newR;
    end else begin
      mPress = mPress | newP; mRel = mRel | newR;
    end
    mLvl = nl;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkEq("key_level", 32'(key_level), 32'(mLvl));
    checkEq("rd_valid", 32'(bus.rd_valid), 32'(mValid));
    checkEq("irq", 32'(bus.irq), 32'(mIrq));
    checkEq("rd_data", 32'(bus.rd_data), 32'(mRdData));
  endtask

  task automatic applyStimulus(input logic [N-1:0] keys, input logic rd);
    key_n = keys;
    bus.rd_en = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic readOnce();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic applyReset();
    resetn = 1'b0;
    modelReset();
    #1;
    checkEq("reset_level", 32'(key_level), 32'h0);
    checkEq("reset_rd_data", 32'(bus.rd_data), 32'h0);
    checkEq("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    checkEq("reset_irq", 32'(bus.irq), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus('1, 1'b0);
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    int  n;
    bit  saw2;
    bus.rd_en = 1'b0;
    modelReset();
    #2;
    applyReset();

    // Idle after reset
    applyStimulus(4'b1111, 1'b0);
    idle(10);
    checkEq("idle_level", 32'(key_level), 32'h0);
    checkEq("idle_irq", 32'(bus.irq), 32'h0);

    // Key 0 press: latency, irq, read
    applyStimulus(4'b1110, 1'b0);
    n = 0;
    do begin tick(); n++; end while (key_level[0] !== 1'b1 && n < 20);
    checkEq("press_latency", 32'(n), 32'(D + 2));
    tick();
    checkEq("irq_rise", 32'(bus.irq), 32'h1);
    readOnce();
    checkEq("read_valid", 32'(bus.rd_valid), 32'h1);
    checkEq("read_0101", 32'(bus.rd_data[15:0]), 32'h0101);
    tick();
    checkEq("irq_clear", 32'(bus.irq), 32'h0);
    checkEq("valid_pulse", 32'(bus.rd_valid), 32'h0);
    applyStimulus(4'b1111, 1'b0);
    idle(D + 6);
    readOnce();
    idle(2);

    // Key 2 bounce never accepted
    saw2 = 1'b0;
    applyStimulus(4'b1011, 1'b0);
    for (int i = 0; i < 5; i++) begin tick(); saw2 |= key_level[2]; end
    applyStimulus(4'b1111, 1'b0);
    tick(); saw2 |= key_level[2];
    applyStimulus(4'b1011, 1'b0);
    for (int i = 0; i < 5; i++) begin tick(); saw2 |= key_level[2]; end
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 15; i++) begin tick(); saw2 |= key_level[2]; end
    checkEq("bounce_level", 32'(saw2), 32'h0);
    checkEq("bounce_irq", 32'(bus.irq), 32'h0);

    // Key 1 accepted on the rd_en cycle
    applyStimulus(4'b1101, 1'b0);
    idle(D + 1);
    readOnce();
    checkEq("coinc_level", 32'(key_level[1]), 32'h1);
    checkEq("coinc_first", 32'(bus.rd_data[1]), 32'h0);
    tick();
    checkEq("coinc_irq", 32'(bus.irq), 32'h1);
    readOnce();
    checkEq("coinc_second", 32'(bus.rd_data[1]), 32'h1);
    tick();
    checkEq("coinc_irq_clr", 32'(bus.irq), 32'h0);
    applyStimulus(4'b1111, 1'b0);
    idle(D + 6);
    readOnce();
    idle(2);

    // Keys 0 and 3 pressed twice, then back-to-back reads
    for (int r = 0; r < 2; r++) begin
      applyStimulus(4'b0110, 1'b0);
      idle(D + 6);
      applyStimulus(4'b1111, 1'b0);
      idle(D + 6);
    end
    bus.rd_en = 1'b1;
    tick();
    checkEq("multi_first", 32'(bus.rd_data[7:0]), 32'h09);
    tick();
    bus.rd_en = 1'b0;
    checkEq("multi_second", 32'(bus.rd_data[7:0]), 32'h00);
    idle(2);

    // Reset while an event is pending, a read is in flight and key 2 is mid-debounce
    applyStimulus(4'b1101, 1'b0);
    idle(D + 4);
    applyStimulus(4'b1001, 1'b1);
    idle(5);
    #2;
    applyReset();
    idle(D + 6);

`ifdef KEY_RELEASE_EVT_EN
    applyStimulus(4'b1110, 1'b0);
    idle(D + 6);
    applyStimulus(4'b1111, 1'b0);
    idle(D + 6);
    readOnce();
    checkEq("rel_press", 32'(bus.rd_data[7:0]), 32'h01);
    checkEq("rel_release", 32'(bus.rd_data[23:16]), 32'h01);
    idle(2);
`endif

    // Random keys and reads
    for (int i = 0; i < 2500; i++) begin
      logic [N-1:0] kn;
      kn = key_n;
      if ($urandom_range(0, 9) == 0) kn[$urandom_range(0, N - 1)] ^= 1'b1;
      applyStimulus(kn, ($urandom_range(0, 5) == 0));
      tick();
    end
    applyStimulus('1, 1'b0);
    idle(D + 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
